pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Control and status bundle between fetch control and pc_sequencer.
// Revision : 1.0
// ============================================================================
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 8
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic                  stall;
    logic [1:0]            sig_pc_src;
    logic                  sig_push_ra;
    logic [ADDR_WIDTH-1:0] I_TypeImmediate;
    logic [ADDR_WIDTH-1:0] J_TypeImmediate;
    logic [ADDR_WIDTH-1:0] PC;
    logic [CW-1:0]         ras_count;
    logic                  ras_empty;
    logic                  ras_full;
    logic                  ras_overflow;
    logic                  ras_underflow;

    modport master (
        output stall, sig_pc_src, sig_push_ra, I_TypeImmediate, J_TypeImmediate,
        input  PC, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, sig_pc_src, sig_push_ra, I_TypeImmediate, J_TypeImmediate,
        output PC, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Next-PC selection with stall, reset vector and circular RAS.
// Revision : 1.0
// ============================================================================
module pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    PC_INC       = 4,
    parameter int                    RAS_DEPTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  wire logic        clock,
    input  wire logic        reset,
    pc_sequencer_if.slave    bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] c_SRC_DEFAULT = 2'b00;
    localparam logic [1:0] c_SRC_RETURN  = 2'b01;
    localparam logic [1:0] c_SRC_BRANCH  = 2'b10;
    localparam logic [1:0] c_SRC_JUMP    = 2'b11;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [PW-1:0]         r_tp;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [ADDR_WIDTH-1:0] r_mem [RAS_DEPTH];

    logic [ADDR_WIDTH-1:0] w_seq_pc;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic                  w_is_ret;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_swap_top;
    logic                  w_push_new;
    logic [PW-1:0]         w_tp_inc;

    assign w_seq_pc   = r_pc + ADDR_WIDTH'(PC_INC);
    assign w_is_ret   = (bus.sig_pc_src == c_SRC_RETURN);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(RAS_DEPTH));
    assign w_pop      = w_is_ret && !w_empty;
    assign w_push     = bus.sig_push_ra;
    // A call coinciding with a real return replaces the top in place
    assign w_swap_top = w_push && w_pop;
    assign w_push_new = w_push && !w_pop;
    assign w_tp_inc   = r_tp + PW'(1);

    always_comb begin
        w_next_pc = w_seq_pc;
        case (bus.sig_pc_src)
            c_SRC_DEFAULT: w_next_pc = w_seq_pc;
            c_SRC_RETURN:  w_next_pc = w_empty ? w_seq_pc : r_mem[r_tp];
            c_SRC_BRANCH:  w_next_pc = r_pc + bus.I_TypeImmediate;
            c_SRC_JUMP:    w_next_pc = r_pc + bus.J_TypeImmediate;
            default:       w_next_pc = w_seq_pc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc        <= RESET_VECTOR;
            r_tp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!bus.stall) begin
            r_pc <= w_next_pc;
            if (w_is_ret && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_push_new) begin
                r_tp <= w_tp_inc;
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else if (w_pop && !w_swap_top) begin
                r_tp    <= r_tp - PW'(1);
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Stack storage carries no reset; only the pointer and count define validity
    always_ff @(posedge clock) begin
        if (!reset && !bus.stall) begin
            if (w_swap_top) begin
                r_mem[r_tp] <= w_seq_pc;
            end else if (w_push_new) begin
                r_mem[w_tp_inc] <= w_seq_pc;
            end
        end
    end

    assign bus.PC            = r_pc;
    assign bus.ras_count     = r_count;
    assign bus.ras_empty     = w_empty;
    assign bus.ras_full      = w_full;
    assign bus.ras_overflow  = r_overflow;
    assign bus.ras_underflow = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed table, corner sequences and random run against a queue model.
// Revision : 1.0
// ============================================================================
module tb_pc_sequencer;
    localparam int          AW  = 32;
    localparam int          DEP = 8;
    localparam logic [31:0] RV  = 32'h100;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pc_sequencer_if #(.ADDR_WIDTH(AW), .RAS_DEPTH(DEP)) bus ();

    pc_sequencer #(
        .ADDR_WIDTH  (AW),
        .PC_INC      (4),
        .RAS_DEPTH   (DEP),
        .RESET_VECTOR(RV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic        stl;
        logic [1:0]  src;
        logic        push;
        logic [31:0] iimm;
        logic [31:0] jimm;
        logic [31:0] epc;
        int          ecnt;
        logic [3:0]  eflags; // {empty, full, overflow, underflow}
    } vec_t;

    // Reference model: return stack as a bounded queue, newest at the back
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    bit          m_ovf, m_unf;

    task automatic model_step(input logic rst, input logic stl, input logic [1:0] src,
                              input logic push, input logic [31:0] iimm, input logic [31:0] jimm);
        logic [31:0] seq, npc;
        bit popped;
        if (rst) begin
            m_pc = RV; m_q.delete(); m_ovf = 0; m_unf = 0;
        end else if (!stl) begin
            seq = m_pc + 32'd4;
            npc = seq;
            popped = 0;
            case (src)
                2'b10: npc = m_pc + iimm;
                2'b11: npc = m_pc + jimm;
                2'b01: if (m_q.size() > 0) begin npc = m_q.pop_back(); popped = 1; end
                       else m_unf = 1;
                default: npc = seq;
            endcase
            if (push) begin
                m_q.push_back(seq);
                if (!popped && m_q.size() > DEP) begin
                    void'(m_q.pop_front());
                    m_ovf = 1;
                end
            end
            m_pc = npc;
        end
    endtask

    task automatic cyc(input logic rst, input logic stl, input logic [1:0] src,
                       input logic push, input logic [31:0] iimm, input logic [31:0] jimm);
        reset               = rst;
        bus.stall           = stl;
        bus.sig_pc_src      = src;
        bus.sig_push_ra     = push;
        bus.I_TypeImmediate = iimm;
        bus.J_TypeImmediate = jimm;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] epc, input int ecnt,
                         input logic [3:0] eflags);
        logic [3:0] aflags;
        aflags = {bus.ras_empty, bus.ras_full, bus.ras_overflow, bus.ras_underflow};
        n_vec++;
        if (bus.PC !== epc || int'(bus.ras_count) != ecnt || aflags !== eflags) begin
            n_err++;
            $display("FAIL %s: got PC=%h count=%0d flags=%b, expected PC=%h count=%0d flags=%b",
                     name, bus.PC, bus.ras_count, aflags, epc, ecnt, eflags);
        end
    endtask

    vec_t tbl[$];

    initial begin
        bus.stall = 0; bus.sig_pc_src = 0; bus.sig_push_ra = 0;
        bus.I_TypeImmediate = 0; bus.J_TypeImmediate = 0;

        //          rst stl src   push iimm          jimm          epc           cnt flags
        tbl.push_back('{1, 0, 2'b00, 0, 32'h0,        32'h0,        32'h100,      0, 4'b1000});
        tbl.push_back('{0, 0, 2'b00, 0, 32'h0,        32'h0,        32'h104,      0, 4'b1000});
        tbl.push_back('{0, 0, 2'b00, 0, 32'h0,        32'h0,        32'h108,      0, 4'b1000});
        tbl.push_back('{0, 0, 2'b00, 0, 32'h0,        32'h0,        32'h10C,      0, 4'b1000});
        tbl.push_back('{0, 0, 2'b11, 0, 32'h0,        32'hF4,       32'h200,      0, 4'b1000});
        tbl.push_back('{0, 0, 2'b11, 1, 32'h0,        32'h40,       32'h240,      1, 4'b0000});
        tbl.push_back('{0, 0, 2'b01, 0, 32'h0,        32'h0,        32'h204,      0, 4'b1000});
        tbl.push_back('{0, 0, 2'b11, 0, 32'h0,        32'hFC,       32'h300,      0, 4'b1000});
        tbl.push_back('{0, 0, 2'b10, 0, 32'hFFFFFFF0, 32'h0,        32'h2F0,      0, 4'b1000});
        tbl.push_back('{0, 0, 2'b11, 0, 32'h0,        32'hFFFFFD0C, 32'hFFFFFFFC, 0, 4'b1000});
        tbl.push_back('{0, 0, 2'b00, 0, 32'h0,        32'h0,        32'h0,        0, 4'b1000});
        tbl.push_back('{0, 0, 2'b11, 1, 32'h0,        32'h4F0,      32'h4F0,      1, 4'b0000});
        tbl.push_back('{0, 0, 2'b00, 1, 32'h0,        32'h0,        32'h4F4,      2, 4'b0000});
        tbl.push_back('{0, 0, 2'b11, 0, 32'h0,        32'hC,        32'h500,      2, 4'b0000});
        tbl.push_back('{0, 0, 2'b01, 1, 32'h0,        32'h0,        32'h4F4,      2, 4'b0000});
        tbl.push_back('{0, 0, 2'b01, 0, 32'h0,        32'h0,        32'h504,      1, 4'b0000});
        tbl.push_back('{0, 0, 2'b01, 0, 32'h0,        32'h0,        32'h4,        0, 4'b1000});
        tbl.push_back('{0, 0, 2'b01, 0, 32'h0,        32'h0,        32'h8,        0, 4'b1001});
        tbl.push_back('{1, 1, 2'b11, 1, 32'h0,        32'h40,       32'h100,      0, 4'b1000});

        foreach (tbl[k]) begin
            cyc(tbl[k].rst, tbl[k].stl, tbl[k].src, tbl[k].push, tbl[k].iimm, tbl[k].jimm);
            check($sformatf("table[%0d]", k), tbl[k].epc, tbl[k].ecnt, tbl[k].eflags);
        end

        // Nine calls into an 8-deep stack, then drain past empty
        cyc(0, 0, 2'b11, 0, 0, 32'hFFFFFF00);
        check("to_zero", 32'h0, 0, 4'b1000);
        for (int k = 0; k < 9; k++) cyc(0, 0, 2'b11, 1, 0, 32'h10);
        check("nine_calls", 32'h90, 8, 4'b0110);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 2'b01, 0, 0, 0);
            check($sformatf("ret[%0d]", k), 32'h84 - 32'(16 * k), 7 - k,
                  (k == 7) ? 4'b1010 : 4'b0010);
        end
        cyc(0, 0, 2'b01, 0, 0, 0);
        check("ret_underflow", 32'h18, 0, 4'b1011);

        // Stall holds everything, then the jump+push lands exactly once
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 2'b11, 1, 0, 32'h40);
            check($sformatf("stall[%0d]", k), 32'h18, 0, 4'b1011);
        end
        cyc(0, 0, 2'b11, 1, 0, 32'h40);
        check("unstall_jal", 32'h58, 1, 4'b0011);
        cyc(0, 0, 2'b00, 0, 0, 0);
        check("after_unstall", 32'h5C, 1, 4'b0011);
        cyc(0, 0, 2'b00, 1, 0, 0);
        cyc(0, 0, 2'b00, 1, 0, 0);
        check("count3", 32'h64, 3, 4'b0011);
        cyc(1, 1, 2'b11, 1, 0, 32'h40);
        check("reset_over_stall", RV, 0, 4'b1000);

        // Random run against the queue model
        model_step(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rand_reset", m_pc, m_q.size(), {m_q.size() == 0, m_q.size() == DEP, m_ovf, m_unf});
        for (int k = 0; k < 3000; k++) begin
            logic        r_rst, r_stl, r_push;
            logic [1:0]  r_src;
            logic [31:0] r_i, r_j;
            r_rst  = ($urandom_range(0, 199) == 0);
            r_stl  = ($urandom_range(0, 4) == 0);
            r_src  = 2'($urandom_range(0, 3));
            r_push = ($urandom_range(0, 9) < 4);
            r_i    = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($signed($urandom_range(0, 511)) - 256);
            r_j    = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($signed($urandom_range(0, 4095)) - 2048);
            model_step(r_rst, r_stl, r_src, r_push, r_i, r_j);
            cyc(r_rst, r_stl, r_src, r_push, r_i, r_j);
            check($sformatf("rand[%0d]", k), m_pc, m_q.size(),
                  {m_q.size() == 0, m_q.size() == DEP, m_ovf, m_unf});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
